stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch digit counter. It synchronises and edge-detects the four raw push-buttons and runs the IDLE/RUN/PAUSE/LAP state machine. It also divides the system clock into count ticks. It drives the counter's count-enable and clear strobes and a display-hold (lap freeze) flag. The counter datapath itself lives outside this block; this block only decides when it counts, clears or is frozen on display.

Parameters:
TICK_DIV, 10, clock cycles per count tick (must be ≥2).
TICK_W, 4, prescaler width (must satisfy 2^TICK_W ≥ TICK_DIV).
STOP_AT_MAX, 1, 1 = auto-pause when the counter is at maximum and a tick is due; 0 = counter wraps freely.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start_resume  in  1  raw button, asynchronous to clk, high = pressed
stop  in  1  raw button, high = pressed
clear  in  1  raw button, high = pressed
lap  in  1  raw button, high = pressed
cnt_max  in  1  from counter: counter currently holds its maximum value
cnt_en  out  1  one-cycle count-enable pulse to counter
cnt_clr  out  1  one-cycle synchronous clear pulse to counter
disp_hold  out  1  high = display frozen (lap)
state  out  2  IDLE=00, RUN=01, PAUSE=10, LAP=11
running  out  1  high in RUN or LAP

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, prescaler=0, cnt_en=0, cnt_clr=0, disp_hold=0, running=0.
  - All synchroniser flops (s1,s2,s3 per button) reset to 1. A button held through reset release produces no event; it must be released and pressed again.
- Button path: 3 flops per button, s1→s2→s3. The event is ev = s2 & ~s3, one cycle per press.
  - A press first sampled at edge N gives ev high during the cycle after edge N+1.
  - The FSM acts on it at edge N+2.
  - Holding the button produces exactly one event.
- Event priority when several fire in the same cycle: clear > stop > start_resume > lap. Only the highest-priority event that is valid in the current state is acted on; the others are dropped.
- FSM transitions (any event not listed is ignored):
  - IDLE: start_resume→RUN. clear→IDLE.
  - RUN: stop→PAUSE. lap→LAP. clear→IDLE.
  - LAP: lap→RUN. stop→PAUSE. clear→IDLE.
  - PAUSE: start_resume→RUN. clear→IDLE.
- Clear accepted in any state (including IDLE): cnt_clr is registered high for exactly the one cycle following the transition edge, and the prescaler is set to 0.
- disp_hold = (state==LAP). It is a registered state decode, with no glitches.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps while state is RUN or LAP.
  - Holds its value in PAUSE, so resuming continues the partial tick.
  - Cleared in IDLE and on IDLE→RUN.
- tick = running & (prescaler==TICK_DIV-1).
- cnt_en = tick & ~(STOP_AT_MAX & cnt_max). It is combinational from registered state only and high at most one cycle per TICK_DIV cycles.
- The first cnt_en after IDLE→RUN occurs in the TICK_DIV-th cycle spent in RUN.
- Auto-stop: if STOP_AT_MAX=1 and tick & cnt_max, cnt_en is suppressed and the FSM goes to PAUSE (LAP also goes to PAUSE, releasing the hold). This ranks below clear and above all other events.
- A stop event in the same cycle as a tick: cnt_en is still asserted that cycle (decoded from the current state), then the FSM enters PAUSE.
- Reset asserted mid-RUN: immediate return to reset values. The counter has its own reset; no cnt_clr is issued.

Test Plan:
- TICK_DIV=4. Release reset, press start_resume one cycle → state=01 two edges later; cnt_en pulses in RUN cycles 4, 8, 12 (every 4 cycles); running=1.
- In RUN, press stop at prescaler=2 → state=10, no cnt_en; press start_resume → the first cnt_en comes 1 cycle after RUN re-entry plus 2-cycle sync latency (prescaler resumes at 2→3).
- RUN, press lap → state=11, disp_hold=1, cnt_en keeps pulsing every 4 cycles; press lap again → state=01, disp_hold=0.
- Press clear and stop in the same cycle from RUN → state=00, cnt_clr high exactly 1 cycle, prescaler=0, no PAUSE visit.
- STOP_AT_MAX=1, cnt_max=1 while running → at the next tick cnt_en stays 0 and state=10; with STOP_AT_MAX=0 → cnt_en=1 and state stays 01.
- Hold start_resume high through reset deassertion → no transition (state=00); release and press → RUN. Assert reset mid-RUN → all outputs 0 and state=00 immediately.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs, counter status and counter/display controls
interface stopwatch_ctrl_if;
  logic       start_resume;
  logic       stop;
  logic       clear;
  logic       lap;
  logic       cnt_max;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_hold;
  logic [1:0] state;
  logic       running;
  modport slave (
    input  start_resume, stop, clear, lap, cnt_max,
    output cnt_en, cnt_clr, disp_hold, state, running
  );
  modport master (
    output start_resume, stop, clear, lap, cnt_max,
    input  cnt_en, cnt_clr, disp_hold, state, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button sync/edge detect, IDLE/RUN/PAUSE/LAP sequencer and tick prescaler
module stopwatch_ctrl #(
  parameter int TICK_DIV    = 10,
  parameter int TICK_W      = 4,
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  stopwatch_ctrl_if.slave sw
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  state_t            r_state, w_next;
  logic [3:0]        r_s1, r_s2, r_s3, w_btn, w_ev;
  logic [TICK_W-1:0] r_pre, w_pre;
  logic              r_clr, r_hold, w_run, w_tick, w_auto;
  assign w_btn  = {sw.lap, sw.clear, sw.stop, sw.start_resume};
  assign w_ev   = r_s2 & ~r_s3;
  assign w_run  = (r_state == RUN) || (r_state == LAP);
  assign w_tick = w_run && (r_pre == TICK_W'(TICK_DIV - 1));
  assign w_auto = STOP_AT_MAX && w_tick && sw.cnt_max;
  // synchronisers reset high so a button held across reset release yields no event
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= '1;
      r_s2    <= '1;
      r_s3    <= '1;
      r_state <= IDLE;
      r_pre   <= '0;
      r_clr   <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_s1    <= w_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_next;
      r_pre   <= w_pre;
      r_clr   <= w_ev[2];
      r_hold  <= (w_next == LAP);
    end
  end
  always_comb begin
    w_next = r_state;
    w_pre  = (w_ev[2] || r_state == IDLE) ? '0 : !w_run ? r_pre : w_tick ? '0 : r_pre + 1'b1;
    if (w_ev[2]) w_next = IDLE;
    else if (w_auto) w_next = PAUSE;
    else begin
      case (r_state)
        IDLE:    w_next = w_ev[0] ? RUN : IDLE;
        RUN:     w_next = w_ev[1] ? PAUSE : w_ev[3] ? LAP : RUN;
        PAUSE:   w_next = w_ev[0] ? RUN : PAUSE;
        LAP:     w_next = w_ev[1] ? PAUSE : w_ev[3] ? RUN : LAP;
        default: w_next = IDLE;
      endcase
    end
  end
  assign sw.cnt_en    = w_tick && !w_auto;
  assign sw.cnt_clr   = r_clr;
  assign sw.disp_hold = r_hold;
  assign sw.state     = r_state;
  assign sw.running   = w_run;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: random and directed button stimulus, scoreboard against a table-driven model
module tb_stopwatch_ctrl;
  localparam int DIV = 4;
  typedef struct packed {logic [1:0] st; logic en; logic clr; logic hold; logic run;} obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn = 4'b0001;
  logic cmax = 1'b0;
  always #5 clk = ~clk;
  stopwatch_ctrl_if if0 ();
  stopwatch_ctrl_if if1 ();
  assign {if0.lap, if0.clear, if0.stop, if0.start_resume} = btn;
  assign {if1.lap, if1.clear, if1.stop, if1.start_resume} = btn;
  assign if0.cnt_max = cmax;
  assign if1.cnt_max = cmax;
  stopwatch_ctrl #(.TICK_DIV(DIV), .TICK_W(3), .STOP_AT_MAX(1'b1)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .sw(if0));
  stopwatch_ctrl #(.TICK_DIV(DIV), .TICK_W(3), .STOP_AT_MAX(1'b0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .sw(if1));
  // destination state per [state][button]; button order start, stop, clear, lap; -1 = ignored
  int tbl [4][4] = '{'{1, -1, -1, -1}, '{-1, 2, -1, 3}, '{1, -1, -1, -1}, '{-1, 2, -1, 1}};
  int prio [3] = '{1, 0, 3};
  int mst [2];
  int mpre [2];
  bit mclr [2];
  logic [3:0] smp [$];
  obs_t q0 [$];
  obs_t q1 [$];
  int passed = 0;
  int total = 0;
  function automatic int nxt(int s, logic [3:0] ev, bit au);
    if (ev[2]) return 0;
    if (au) return 2;
    foreach (prio[i]) if (ev[prio[i]] && tbl[s][prio[i]] >= 0) return tbl[s][prio[i]];
    return s;
  endfunction
  task automatic model_reset();
    mst = '{0, 0};
    mpre = '{0, 0};
    mclr = '{0, 0};
    smp = '{4'hF, 4'hF, 4'hF};
  endtask
  // a press sampled at edge N is acted on at edge N+2
  task automatic model_edge();
    logic [3:0] ev;
    bit run, tick, au;
    int ns;
    ev = smp[1] & ~smp[2];
    for (int k = 0; k < 2; k++) begin
      run = (mst[k] == 1) || (mst[k] == 3);
      tick = run && (mpre[k] == DIV - 1);
      au = (k == 0) && tick && cmax;
      ns = nxt(mst[k], ev, au);
      mpre[k] = (ev[2] || mst[k] == 0) ? 0 : run ? (mpre[k] + 1) % DIV : mpre[k];
      mclr[k] = ev[2];
      mst[k] = ns;
    end
    smp.push_front(btn);
    void'(smp.pop_back());
  endtask
  function automatic obs_t expect_k(int k);
    obs_t o;
    bit run, tick;
    run = (mst[k] == 1) || (mst[k] == 3);
    tick = run && (mpre[k] == DIV - 1);
    o.st = 2'(mst[k]);
    o.en = tick && !((k == 0) && cmax);
    o.clr = mclr[k];
    o.hold = (mst[k] == 3);
    o.run = run;
    return o;
  endfunction
  task automatic cyc(input logic [3:0] b, input logic cm, input logic r);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    btn = b;
    cmax = cm;
    rst_n = r;
    if (!r) model_reset();
    q0.push_back(expect_k(0));
    q1.push_back(expect_k(1));
  endtask
  task automatic check(input int k, input obs_t e, input obs_t a);
    total++;
    if (a !== e)
      $display("FAIL sw%0d t=%0t got st=%b en=%b clr=%b hold=%b run=%b want st=%b en=%b clr=%b hold=%b run=%b",
               k, $time, a.st, a.en, a.clr, a.hold, a.run, e.st, e.en, e.clr, e.hold, e.run);
    else passed++;
  endtask
  initial forever begin
    @(negedge clk);
    if (q0.size() > 0) check(0, q0.pop_front(), {if0.state, if0.cnt_en, if0.cnt_clr, if0.disp_hold, if0.running});
    if (q1.size() > 0) check(1, q1.pop_front(), {if1.state, if1.cnt_en, if1.cnt_clr, if1.disp_hold, if1.running});
  end
  initial begin
    int hold;
    logic [3:0] rb;
    logic rc;
    hold = 0;
    rb = '0;
    rc = 1'b0;
    model_reset();
    repeat (3) cyc(4'b0001, 1'b0, 1'b0);
    repeat (5) cyc(4'b0001, 1'b0, 1'b1);
    repeat (2) cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b1);
    repeat (14) cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b1);
    repeat (6) cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b1);
    repeat (8) cyc(4'b0000, 1'b0, 1'b1);
    repeat (3) cyc(4'b1000, 1'b0, 1'b1);
    repeat (10) cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    repeat (6) cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0110, 1'b0, 1'b1);
    repeat (5) cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b1);
    repeat (3) cyc(4'b0000, 1'b0, 1'b1);
    repeat (8) cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b0100, 1'b0, 1'b1);
    repeat (4) cyc(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        rb = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) rb[2] = 1'b0;
        if ($urandom_range(0, 1) != 0) rb = '0;
        rc = ($urandom_range(0, 7) == 0);
        hold = $urandom_range(1, 4);
      end
      hold--;
      cyc(rb, rc, 1'b1);
    end
    cyc(4'b0100, 1'b0, 1'b1);
    repeat (3) cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b1);
    repeat (7) cyc(4'b0000, 1'b0, 1'b1);
    repeat (2) cyc(4'b0000, 1'b0, 1'b0);
    repeat (6) cyc(4'b0000, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
